// File: rtl/remote_load_latency_pkg.sv
// Shared definitions for the remote-load latency histogram.
//   rll_sel_e  : read-select encoding for rd_sel_i (bins start at e_rll_bin0)
//   rll_type_e : load classes tracked per type
//   rll_bin    : histogram bin index for a latency value
package remote_load_latency_pkg;

  typedef enum logic [3:0] {
    e_rll_count     = 4'd0,
    e_rll_sum       = 4'd1,
    e_rll_min       = 4'd2,
    e_rll_max       = 4'd3,
    e_rll_orphan    = 4'd4,
    e_rll_overwrite = 4'd5,
    e_rll_bin0      = 4'd8
  } rll_sel_e;

  typedef enum logic [1:0] {
    e_rll_int    = 2'd0,
    e_rll_float  = 2'd1,
    e_rll_icache = 2'd2
  } rll_type_e;

  // Bin = MSB position of the latency (0 for latency <= 1), clamped to the
  // last bin so long tails all land in one bucket.
  function automatic int rll_bin(input logic [31:0] lat, input int num_bins);
    int b;
    b = 0;
    for (int i = 1; i < 32; i++)
      if (lat[i]) b = i;
    if (b > num_bins - 1) b = num_bins - 1;
    return b;
  endfunction

endpackage

// File: rtl/remote_load_latency_stats.sv
// Per-type statistics accumulators for remote-load latencies.
//   clk_i/reset_i : clock, async active-high reset
//   clear_i       : synchronous clear, dominates any update this cycle
//   smp_v_i       : a latency sample (lat_i, bin_i) is applied this cycle
//   orphan_i      : bump the orphan counter
//   overwrite_i   : bump the overwrite counter
//   rd_sel_i      : read select, rd_data_o is the combinational read mux
module remote_load_latency_stats
  import remote_load_latency_pkg::*;
#(
  parameter int num_bins_p  = 8,
  parameter int ts_width_p  = 16,
  parameter int ctr_width_p = 32,
  parameter int sum_width_p = 48,
  localparam int bin_width_lp = $clog2(num_bins_p),
  localparam int sel_width_lp = $clog2(8 + num_bins_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    smp_v_i,
  input  logic [ts_width_p-1:0]   lat_i,
  input  logic [bin_width_lp-1:0] bin_i,
  input  logic                    orphan_i,
  input  logic                    overwrite_i,
  input  logic [sel_width_lp-1:0] rd_sel_i,
  output logic [sum_width_p-1:0]  rd_data_o
);
  localparam int wcs_lp  = (sum_width_p > ctr_width_p) ? sum_width_p : ctr_width_p;
  localparam int wide_lp = (wcs_lp > ts_width_p) ? wcs_lp : ts_width_p;
  localparam int acc_lp  = ((sum_width_p > ts_width_p) ? sum_width_p : ts_width_p) + 1;

  logic [ctr_width_p-1:0] count_q, count_d, orphan_q, orphan_d, overwrite_q, overwrite_d;
  logic [sum_width_p-1:0] sum_q, sum_d;
  logic [ts_width_p-1:0]  min_q, min_d, max_q, max_d;
  logic [num_bins_p-1:0][ctr_width_p-1:0] bins_q, bins_d;
  logic [acc_lp-1:0]      sum_ext;
  logic [wide_lp-1:0]     rd_wide;

  always_comb begin
    count_d     = count_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    orphan_d    = orphan_q;
    overwrite_d = overwrite_q;
    bins_d      = bins_q;
    // Extra headroom bit turns saturation into a simple compare.
    sum_ext     = acc_lp'(sum_q) + acc_lp'(lat_i);
    if (smp_v_i) begin
      if (count_q != '1) count_d = count_q + ctr_width_p'(1);
      sum_d = (sum_ext > acc_lp'({sum_width_p{1'b1}})) ? '1 : sum_ext[sum_width_p-1:0];
      if (lat_i < min_q) min_d = lat_i;
      if (lat_i > max_q) max_d = lat_i;
      for (int k = 0; k < num_bins_p; k++)
        if (int'(bin_i) == k && bins_q[k] != '1) bins_d[k] = bins_q[k] + ctr_width_p'(1);
    end
    if (orphan_i && orphan_q != '1)       orphan_d    = orphan_q + ctr_width_p'(1);
    if (overwrite_i && overwrite_q != '1) overwrite_d = overwrite_q + ctr_width_p'(1);
    if (clear_i) begin
      count_d = '0; sum_d = '0; min_d = '1; max_d = '0;
      orphan_d = '0; overwrite_d = '0; bins_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0; sum_q <= '0; min_q <= '1; max_q <= '0;
      orphan_q <= '0; overwrite_q <= '0; bins_q <= '0;
    end else begin
      count_q <= count_d; sum_q <= sum_d; min_q <= min_d; max_q <= max_d;
      orphan_q <= orphan_d; overwrite_q <= overwrite_d; bins_q <= bins_d;
    end
  end

  // Reserved selects and bins beyond num_bins_p fall through to zero.
  always_comb begin
    rd_wide = '0;
    case (int'(rd_sel_i))
      int'(e_rll_count):     rd_wide = wide_lp'(count_q);
      int'(e_rll_sum):       rd_wide = wide_lp'(sum_q);
      int'(e_rll_min):       rd_wide = wide_lp'(min_q);
      int'(e_rll_max):       rd_wide = wide_lp'(max_q);
      int'(e_rll_orphan):    rd_wide = wide_lp'(orphan_q);
      int'(e_rll_overwrite): rd_wide = wide_lp'(overwrite_q);
      default:
        for (int k = 0; k < num_bins_p; k++)
          if (int'(rd_sel_i) == int'(e_rll_bin0) + k) rd_wide = wide_lp'(bins_q[k]);
    endcase
  end

  assign rd_data_o = rd_wide[sum_width_p-1:0];

endmodule

// File: rtl/remote_load_latency_histogram.sv
// Remote-load latency histogram: tracks outstanding loads per type/tag,
// timestamps launches against a free-running counter and feeds each
// launch-to-return latency into per-type statistics.
//   clk_i/reset_i          : clock, async active-high reset
//   enable_i               : gates statistics (pending tracking always live)
//   clear_i                : clears stats, pending bits and in-flight sample
//   launch_*/return_*      : launch and accepted-response events
//   rd_v_i/rd_type_i/rd_sel_i -> rd_v_o/rd_data_o : 1-cycle registered read
//   pending_o              : per type, any tag outstanding (registered)
module remote_load_latency_histogram
  import remote_load_latency_pkg::*;
#(
  parameter int num_types_p = 3,
  parameter int num_tags_p  = 32,
  parameter int num_bins_p  = 8,
  parameter int ts_width_p  = 16,
  parameter int ctr_width_p = 32,
  parameter int sum_width_p = 48,
  localparam int type_width_lp = $clog2(num_types_p),
  localparam int tag_width_lp  = $clog2(num_tags_p),
  localparam int sel_width_lp  = $clog2(8 + num_bins_p),
  localparam int bin_width_lp  = $clog2(num_bins_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     launch_v_i,
  input  logic [type_width_lp-1:0] launch_type_i,
  input  logic [tag_width_lp-1:0]  launch_tag_i,
  input  logic                     return_v_i,
  input  logic [type_width_lp-1:0] return_type_i,
  input  logic [tag_width_lp-1:0]  return_tag_i,
  input  logic                     rd_v_i,
  input  logic [type_width_lp-1:0] rd_type_i,
  input  logic [sel_width_lp-1:0]  rd_sel_i,
  output logic                     rd_v_o,
  output logic [sum_width_p-1:0]   rd_data_o,
  output logic [num_types_p-1:0]   pending_o
);
  logic [ts_width_p-1:0] ts_q, ts_d;
  logic [num_types_p-1:0][num_tags_p-1:0] pend_q, pend_d;
  logic [num_types_p-1:0][num_tags_p-1:0][ts_width_p-1:0] start_q, start_d;
  logic [num_types_p-1:0] smp_q, smp_d, orph_q, orph_d, ovw_q, ovw_d, pending_q, pending_d;
  logic [ts_width_p-1:0]   lat_q, lat_d;
  logic [bin_width_lp-1:0] bin_q, bin_d;
  logic                    rd_v_q, rd_v_d;
  logic [sum_width_p-1:0]  rd_data_q, rd_data_d;
  logic [num_types_p-1:0][sum_width_p-1:0] stats_rd;

  logic                    lau_ok, ret_ok, same_slot;
  logic [tag_width_lp-1:0] l_tag, r_tag;

  // The icache class has a single slot, so its tag is forced to 0.
  assign l_tag  = (launch_type_i == type_width_lp'(e_rll_icache)) ? '0 : launch_tag_i;
  assign r_tag  = (return_type_i == type_width_lp'(e_rll_icache)) ? '0 : return_tag_i;
  assign lau_ok = launch_v_i && (int'(launch_type_i) < num_types_p);
  assign ret_ok = return_v_i && (int'(return_type_i) < num_types_p);
  assign same_slot = ret_ok && (return_type_i == launch_type_i) && (r_tag == l_tag);

  always_comb begin
    ts_d    = ts_q + ts_width_p'(1);
    pend_d  = pend_q;
    start_d = start_q;
    smp_d   = '0;
    orph_d  = '0;
    ovw_d   = '0;
    lat_d   = ts_q - start_q[return_type_i][r_tag];
    bin_d   = bin_width_lp'(rll_bin(32'(lat_d), num_bins_p));
    // Return is processed before launch so a same-slot pair consumes the
    // old start time and then installs the new one.
    if (ret_ok) begin
      if (pend_q[return_type_i][r_tag]) begin
        pend_d[return_type_i][r_tag] = 1'b0;
        smp_d[return_type_i]         = enable_i;
      end else begin
        orph_d[return_type_i] = enable_i;
      end
    end
    if (lau_ok) begin
      if (pend_q[launch_type_i][l_tag] && !same_slot) ovw_d[launch_type_i] = enable_i;
      pend_d[launch_type_i][l_tag]  = 1'b1;
      start_d[launch_type_i][l_tag] = ts_q;
    end
    if (clear_i) begin
      pend_d = '0;
      smp_d  = '0;
      orph_d = '0;
      ovw_d  = '0;
    end
    for (int t = 0; t < num_types_p; t++) pending_d[t] = |pend_d[t];
    rd_v_d    = rd_v_i;
    rd_data_d = '0;
    if (rd_v_i && int'(rd_type_i) < num_types_p) rd_data_d = stats_rd[rd_type_i];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q <= '0; pend_q <= '0; start_q <= '0;
      smp_q <= '0; orph_q <= '0; ovw_q <= '0; lat_q <= '0; bin_q <= '0;
      pending_q <= '0; rd_v_q <= 1'b0; rd_data_q <= '0;
    end else begin
      ts_q <= ts_d; pend_q <= pend_d; start_q <= start_d;
      smp_q <= smp_d; orph_q <= orph_d; ovw_q <= ovw_d; lat_q <= lat_d; bin_q <= bin_d;
      pending_q <= pending_d; rd_v_q <= rd_v_d; rd_data_q <= rd_data_d;
    end
  end

  for (genvar t = 0; t < num_types_p; t++) begin : g_stats
    remote_load_latency_stats #(
      .num_bins_p (num_bins_p),
      .ts_width_p (ts_width_p),
      .ctr_width_p(ctr_width_p),
      .sum_width_p(sum_width_p)
    ) u_stats (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .clear_i    (clear_i),
      .smp_v_i    (smp_q[t]),
      .lat_i      (lat_q),
      .bin_i      (bin_q),
      .orphan_i   (orph_q[t]),
      .overwrite_i(ovw_q[t]),
      .rd_sel_i   (rd_sel_i),
      .rd_data_o  (stats_rd[t])
    );
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_remote_load_latency_histogram.sv
// Self-checking bench for remote_load_latency_histogram. A second instance
// with an 8-bit sum shares all inputs to exercise sum saturation.
module tb_remote_load_latency_histogram;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, enable_i, clear_i, launch_v_i, return_v_i, rd_v_i;
  logic [1:0] launch_type_i, return_type_i, rd_type_i;
  logic [4:0] launch_tag_i, return_tag_i;
  logic [3:0] rd_sel_i;
  logic rd_v_o, rd_v8;
  logic [47:0] rd_data_o;
  logic [7:0] rd8;
  logic [2:0] pending_o, pend8;

  remote_load_latency_histogram dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .launch_v_i(launch_v_i), .launch_type_i(launch_type_i), .launch_tag_i(launch_tag_i),
    .return_v_i(return_v_i), .return_type_i(return_type_i), .return_tag_i(return_tag_i),
    .rd_v_i(rd_v_i), .rd_type_i(rd_type_i), .rd_sel_i(rd_sel_i),
    .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .pending_o(pending_o));

  remote_load_latency_histogram #(.sum_width_p(8)) dut8 (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .launch_v_i(launch_v_i), .launch_type_i(launch_type_i), .launch_tag_i(launch_tag_i),
    .return_v_i(return_v_i), .return_type_i(return_type_i), .return_tag_i(return_tag_i),
    .rd_v_i(rd_v_i), .rd_type_i(rd_type_i), .rd_sel_i(rd_sel_i),
    .rd_v_o(rd_v8), .rd_data_o(rd8), .pending_o(pend8));

  // Reference model: outstanding slots and plain-integer statistics.
  int     m_ts;
  bit     mp[3][32];
  int     ms[3][32];
  longint m_cnt[3], m_sum[3], m_sum8[3], m_min[3], m_max[3], m_orph[3], m_ovw[3];
  longint m_bin[3][8];
  int n_checks = 0, n_fail = 0;
  longint d, d8;

  function automatic void m_clear();
    for (int t = 0; t < 3; t++) begin
      m_cnt[t] = 0; m_sum[t] = 0; m_sum8[t] = 0; m_min[t] = 65535; m_max[t] = 0;
      m_orph[t] = 0; m_ovw[t] = 0;
      for (int b = 0; b < 8; b++) m_bin[t][b] = 0;
      for (int g = 0; g < 32; g++) mp[t][g] = 0;
    end
  endfunction

  function automatic int ref_bin(int lat);
    int b;
    if (lat <= 1) return 0;
    b = $clog2(lat + 1) - 1;
    return (b > 7) ? 7 : b;
  endfunction

  function automatic void m_step(bit lv, int lt, int ltg, bit rv, int rt, int rtg);
    int tg, lat;
    if (clear_i) begin m_clear(); return; end
    if (rv) begin
      tg = (rt == 2) ? 0 : rtg;
      if (mp[rt][tg]) begin
        lat = (m_ts - ms[rt][tg]) & 16'hFFFF;
        mp[rt][tg] = 0;
        if (enable_i) begin
          m_cnt[rt]++;
          m_sum[rt] += lat;
          m_sum8[rt] = (m_sum8[rt] + lat > 255) ? 255 : m_sum8[rt] + lat;
          if (lat < m_min[rt]) m_min[rt] = lat;
          if (lat > m_max[rt]) m_max[rt] = lat;
          m_bin[rt][ref_bin(lat)]++;
        end
      end else if (enable_i) m_orph[rt]++;
    end
    if (lv) begin
      tg = (lt == 2) ? 0 : ltg;
      if (mp[lt][tg] && enable_i) m_ovw[lt]++;
      mp[lt][tg] = 1;
      ms[lt][tg] = m_ts;
    end
  endfunction

  function automatic longint m_exp(int t, int s);
    case (s)
      0: return m_cnt[t];
      1: return m_sum[t];
      2: return m_min[t];
      3: return m_max[t];
      4: return m_orph[t];
      5: return m_ovw[t];
      6, 7: return 0;
      default: return m_bin[t][s-8];
    endcase
  endfunction

  function automatic logic [2:0] m_pend();
    logic [2:0] p;
    p = '0;
    for (int t = 0; t < 3; t++)
      for (int g = 0; g < 32; g++) if (mp[t][g]) p[t] = 1'b1;
    return p;
  endfunction

  task automatic cycle(input bit lv, input int lt, input int ltg, input bit rv, input int rt,
                       input int rtg, input bit rdv = 0, input int rdt = 0, input int rds = 0);
    launch_v_i = lv; launch_type_i = 2'(lt); launch_tag_i = 5'(ltg);
    return_v_i = rv; return_type_i = 2'(rt); return_tag_i = 5'(rtg);
    rd_v_i = rdv; rd_type_i = 2'(rdt); rd_sel_i = 4'(rds);
    m_step(lv, lt, ltg, rv, rt, rtg);
    @(posedge clk); #1;
    m_ts = (m_ts + 1) & 16'hFFFF;
    launch_v_i = 0; return_v_i = 0; rd_v_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_ts(input int t);
    while (m_ts < t) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int t, input int s, output longint v, output longint v8);
    cycle(0, 0, 0, 0, 0, 0, 1, t, s);
    v = rd_data_o;
    v8 = rd8;
  endtask

  task automatic do_reset();
    reset_i = 1; enable_i = 1; clear_i = 0;
    launch_v_i = 0; return_v_i = 0; rd_v_i = 0;
    launch_type_i = 0; launch_tag_i = 0; return_type_i = 0; return_tag_i = 0;
    rd_type_i = 0; rd_sel_i = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_i = 0;
    m_clear();
    m_ts = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rd_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_v got %0b want 0", rd_v_o); end
    n_checks++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_rd_data got %0h want 0", rd_data_o); end
    n_checks++; if (pending_o !== 3'b000) begin n_fail++; $display("FAIL reset_pending got %b want 000", pending_o); end
    rd(0, 0, d, d8);
    n_checks++; if (rd_v_o !== 1'b1) begin n_fail++; $display("FAIL read_valid got %0b want 1", rd_v_o); end
    n_checks++; if (d != 0) begin n_fail++; $display("FAIL reset_count got %0d want 0", d); end
    rd(1, 2, d, d8);
    n_checks++; if (d != 65535) begin n_fail++; $display("FAIL reset_min got %0d want 65535", d); end
    idle(1);
    n_checks++; if (rd_v_o !== 1'b0) begin n_fail++; $display("FAIL read_valid_drop got %0b want 0", rd_v_o); end
  endtask

  task automatic test_basic();
    do_reset();
    goto_ts(10);
    cycle(1, 0, 5, 0, 0, 0);
    n_checks++; if (pending_o !== 3'b001) begin n_fail++; $display("FAIL basic_pending got %b want 001", pending_o); end
    goto_ts(17);
    cycle(0, 0, 0, 1, 0, 5);
    n_checks++; if (pending_o !== 3'b000) begin n_fail++; $display("FAIL basic_pending_clr got %b want 000", pending_o); end
    idle(1);
    rd(0, 0, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL basic_count got %0d want 1", d); end
    rd(0, 1, d, d8); n_checks++; if (d != 7) begin n_fail++; $display("FAIL basic_sum got %0d want 7", d); end
    rd(0, 2, d, d8); n_checks++; if (d != 7) begin n_fail++; $display("FAIL basic_min got %0d want 7", d); end
    rd(0, 3, d, d8); n_checks++; if (d != 7) begin n_fail++; $display("FAIL basic_max got %0d want 7", d); end
    rd(0, 10, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL basic_bin2 got %0d want 1", d); end
    rd(0, 6, d, d8); n_checks++; if (d != 0) begin n_fail++; $display("FAIL reserved_sel got %0d want 0", d); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 0, 1, 0, 0, 0);
    idle(3);
    cycle(0, 0, 0, 1, 0, 1);
    rd(0, 0, d, d8); n_checks++; if (d != 0) begin n_fail++; $display("FAIL early_read got %0d want 0", d); end
    rd(0, 0, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL visible_read got %0d want 1", d); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    cycle(1, 1, 3, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0);
    goto_ts(9);  cycle(0, 0, 0, 1, 1, 4);
    goto_ts(40); cycle(0, 0, 0, 1, 1, 3);
    idle(1);
    rd(1, 0, d, d8);  n_checks++; if (d != 2)  begin n_fail++; $display("FAIL ooo_count got %0d want 2", d); end
    rd(1, 1, d, d8);  n_checks++; if (d != 48) begin n_fail++; $display("FAIL ooo_sum got %0d want 48", d); end
    rd(1, 2, d, d8);  n_checks++; if (d != 8)  begin n_fail++; $display("FAIL ooo_min got %0d want 8", d); end
    rd(1, 3, d, d8);  n_checks++; if (d != 40) begin n_fail++; $display("FAIL ooo_max got %0d want 40", d); end
    rd(1, 11, d, d8); n_checks++; if (d != 1)  begin n_fail++; $display("FAIL ooo_bin3 got %0d want 1", d); end
    rd(1, 12, d, d8); n_checks++; if (d != 0)  begin n_fail++; $display("FAIL ooo_bin4 got %0d want 0", d); end
    rd(1, 13, d, d8); n_checks++; if (d != 1)  begin n_fail++; $display("FAIL ooo_bin5 got %0d want 1", d); end
  endtask

  task automatic test_orphan_overwrite();
    do_reset();
    cycle(0, 0, 0, 1, 2, 9);
    cycle(1, 0, 2, 0, 0, 0);
    cycle(1, 0, 2, 0, 0, 0);
    cycle(1, 2, 7, 0, 0, 0);
    cycle(0, 0, 0, 1, 2, 3);
    idle(1);
    rd(2, 4, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL orphan got %0d want 1", d); end
    rd(2, 0, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL icache_count got %0d want 1", d); end
    rd(0, 5, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL overwrite got %0d want 1", d); end
    rd(0, 0, d, d8); n_checks++; if (d != 0) begin n_fail++; $display("FAIL ovw_count got %0d want 0", d); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    goto_ts(100); cycle(1, 0, 7, 0, 0, 0);
    goto_ts(130); cycle(1, 0, 7, 1, 0, 7);
    n_checks++; if (pending_o !== 3'b001) begin n_fail++; $display("FAIL same_pending got %b want 001", pending_o); end
    goto_ts(135); cycle(0, 0, 0, 1, 0, 7);
    idle(1);
    rd(0, 1, d, d8); n_checks++; if (d != 35) begin n_fail++; $display("FAIL same_sum got %0d want 35", d); end
    rd(0, 2, d, d8); n_checks++; if (d != 5)  begin n_fail++; $display("FAIL same_min got %0d want 5", d); end
    rd(0, 3, d, d8); n_checks++; if (d != 30) begin n_fail++; $display("FAIL same_max got %0d want 30", d); end
    rd(0, 5, d, d8); n_checks++; if (d != 0)  begin n_fail++; $display("FAIL same_overwrite got %0d want 0", d); end
  endtask

  task automatic test_saturation();
    int a;
    do_reset();
    a = m_ts; cycle(1, 0, 0, 0, 0, 0); goto_ts(a + 1000); cycle(0, 0, 0, 1, 0, 0);
    a = m_ts; cycle(1, 1, 0, 0, 0, 0); goto_ts(a + 200);  cycle(0, 0, 0, 1, 1, 0);
    a = m_ts; cycle(1, 1, 1, 0, 0, 0); goto_ts(a + 100);  cycle(0, 0, 0, 1, 1, 1);
    idle(1);
    rd(0, 15, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL bin_clamp got %0d want 1", d); end
    rd(0, 3, d, d8);  n_checks++; if (d != 1000) begin n_fail++; $display("FAIL max_1000 got %0d want 1000", d); end
    rd(1, 1, d, d8);
    n_checks++; if (d8 != 255) begin n_fail++; $display("FAIL sum_sat got %0d want 255", d8); end
    n_checks++; if (d != 300)  begin n_fail++; $display("FAIL sum_wide got %0d want 300", d); end
  endtask

  task automatic test_clear_reset();
    do_reset();
    cycle(1, 0, 1, 0, 0, 0); cycle(1, 1, 2, 0, 0, 0); cycle(1, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1);
    idle(2);
    clear_i = 1; cycle(1, 0, 5, 1, 1, 2); clear_i = 0;
    n_checks++; if (pending_o !== 3'b000) begin n_fail++; $display("FAIL clear_pending got %b want 000", pending_o); end
    rd(0, 0, d, d8); n_checks++; if (d != 0) begin n_fail++; $display("FAIL clear_count got %0d want 0", d); end
    rd(0, 2, d, d8); n_checks++; if (d != 65535) begin n_fail++; $display("FAIL clear_min got %0d want 65535", d); end
    cycle(0, 0, 0, 1, 1, 2);
    idle(1);
    rd(1, 4, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL clear_orphan got %0d want 1", d); end
    cycle(1, 0, 4, 0, 0, 0);
    reset_i = 1; #1;
    n_checks++; if (pending_o !== 3'b000) begin n_fail++; $display("FAIL rst_pending got %b want 000", pending_o); end
    do_reset();
    rd(1, 4, d, d8); n_checks++; if (d != 0) begin n_fail++; $display("FAIL rst_orphan got %0d want 0", d); end
    cycle(0, 0, 0, 1, 0, 4);
    idle(1);
    rd(0, 4, d, d8); n_checks++; if (d != 1) begin n_fail++; $display("FAIL rst_orphan_after got %0d want 1", d); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable_i = ($urandom % 8) != 0;
      clear_i  = ($urandom % 64) == 0;
      cycle($urandom % 2, $urandom % 3, $urandom % 4, $urandom % 2, $urandom % 3, $urandom % 4);
      n_checks++;
      if (pending_o !== m_pend()) begin n_fail++; $display("FAIL rand_pending cyc %0d got %b want %b", i, pending_o, m_pend()); end
    end
    enable_i = 1; clear_i = 0;
    idle(2);
    for (int t = 0; t < 3; t++)
      for (int s = 0; s < 16; s++) begin
        rd(t, s, d, d8);
        n_checks++;
        if (d != m_exp(t, s)) begin n_fail++; $display("FAIL rand_stat t%0d sel%0d got %0d want %0d", t, s, d, m_exp(t, s)); end
        if (s == 1) begin
          n_checks++;
          if (d8 != m_sum8[t]) begin n_fail++; $display("FAIL rand_sum8 t%0d got %0d want %0d", t, d8, m_sum8[t]); end
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_out_of_order();
    test_orphan_overwrite();
    test_same_cycle();
    test_saturation();
    test_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
